// File: rtl/gcm_pkg.sv
// gcm_pkg: shared definitions for the GCM GCTR data path.
//   - gctr_state_t : GCTR controller FSM states
//   - BLK_W        : AES / GCM block width in bits
//   - CNT_W_DEFAULT: default width of the incremented counter field
//   - byte_mask()  : keeps leading bytes of a block, zeroes the rest
package gcm_pkg;

    localparam int unsigned BLK_W         = 128;
    localparam int unsigned CNT_W_DEFAULT = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_DATA,
        ST_START,
        ST_ENC,
        ST_OUT
    } gctr_state_t;

    // Byte 0 is bits [0:7]. nbytes = 0 means the whole block is valid.
    function automatic logic [0:BLK_W-1] byte_mask(input logic [0:3] nbytes);
        logic [0:BLK_W-1] m;
        m = '1;
        if (nbytes != 4'd0) begin
            for (int unsigned b = 0; b < BLK_W / 8; b++) begin
                if (b >= {28'd0, nbytes}) begin
                    m[b*8 +: 8] = 8'h00;
                end
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/gctr_inc.sv
// gctr_inc: combinational inc32-style counter block incrementer.
//   i_cb   : current counter block, bit 0 = MSB
//   i_init : counter field value captured at ICB load
//   o_cb   : i_cb with its low CNT_W bits incremented modulo 2^CNT_W
//   o_wrap : incremented field equals i_init (full counter period used)
module gctr_inc
    import gcm_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic [0:BLK_W-1] i_cb,
    input  logic [CNT_W-1:0] i_init,
    output logic [0:BLK_W-1] o_cb,
    output logic             o_wrap
);

    logic [CNT_W-1:0] w_field;
    logic [CNT_W-1:0] w_field_inc;

    assign w_field     = i_cb[BLK_W-CNT_W:BLK_W-1];
    assign w_field_inc = w_field + {{(CNT_W-1){1'b0}}, 1'b1};
    assign o_cb        = {i_cb[0:BLK_W-CNT_W-1], w_field_inc};
    assign o_wrap      = (w_field_inc == i_init);

endmodule

// File: rtl/gctr_ctrl.sv
// gctr_ctrl: GCM GCTR controller. Sends the running counter block to the
// AES core for every data block, XORs the keystream with the data and
// advances the low CNT_W-bit counter field.
// Ports:
//   iClk, iRst_n (sync, active low), iClear (sync abort to IDLE)
//   iICB/iICB_valid/oICB_ready        : initial counter block load
//   iIn/iIn_last/iIn_valid/oIn_ready  : data block input
//   oAES_block/oAES_start             : request to AES core
//   iAES_done/iAES_result             : keystream from AES core
//   oOut/oOut_valid/iOut_ready        : XOR result stream
//   oDone, oWrap_err, oBlk_cnt        : status
// Build option: define GCTR_PARTIAL_EN to add iIn_bytes, which truncates
// the final block of a message to its leading iIn_bytes bytes.
module gctr_ctrl
    import gcm_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iClear,
    input  logic [0:BLK_W-1] iICB,
    input  logic             iICB_valid,
    output logic             oICB_ready,
    input  logic [0:BLK_W-1] iIn,
    input  logic             iIn_last,
    input  logic             iIn_valid,
`ifdef GCTR_PARTIAL_EN
    input  logic [0:3]       iIn_bytes,
`endif
    output logic             oIn_ready,
    output logic [0:BLK_W-1] oAES_block,
    output logic             oAES_start,
    input  logic             iAES_done,
    input  logic [0:BLK_W-1] iAES_result,
    output logic [0:BLK_W-1] oOut,
    output logic             oOut_valid,
    input  logic             iOut_ready,
    output logic             oDone,
    output logic             oWrap_err,
    output logic [31:0]      oBlk_cnt
);

    gctr_state_t      r_state;
    gctr_state_t      w_next_state;
    logic [0:BLK_W-1] r_cb;
    logic [CNT_W-1:0] r_init;
    logic [0:BLK_W-1] r_data;
    logic             r_last;
    logic [0:BLK_W-1] r_out;
    logic             r_done;
    logic             r_wrap;
    logic [31:0]      r_blk_cnt;
    logic [0:BLK_W-1] w_cb_next;
    logic             w_wrap;
    logic [0:BLK_W-1] w_keyed;

    gctr_inc #(
        .CNT_W (CNT_W)
    ) u_inc (
        .i_cb   (r_cb),
        .i_init (r_init),
        .o_cb   (w_cb_next),
        .o_wrap (w_wrap)
    );

`ifdef GCTR_PARTIAL_EN
    logic [0:3] r_bytes;
    assign w_keyed = (r_data ^ iAES_result) & (r_last ? byte_mask(r_bytes) : '1);
`else
    assign w_keyed = r_data ^ iAES_result;
`endif

    always_ff @(posedge iClk) begin
        if (!iRst_n || iClear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        oICB_ready   = 1'b0;
        oIn_ready    = 1'b0;
        oAES_start   = 1'b0;
        oAES_block   = '0;
        oOut_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                oICB_ready = 1'b1;
                if (iICB_valid) w_next_state = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                oIn_ready = 1'b1;
                if (iIn_valid) w_next_state = ST_START;
            end
            ST_START: begin
                oAES_start   = 1'b1;
                oAES_block   = r_cb;
                w_next_state = ST_ENC;
            end
            ST_ENC: begin
                oAES_block = r_cb;
                if (iAES_done) w_next_state = ST_OUT;
            end
            ST_OUT: begin
                oOut_valid = 1'b1;
                if (iOut_ready) w_next_state = r_last ? ST_IDLE : ST_WAIT_DATA;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n || iClear) begin
            r_cb      <= '0;
            r_init    <= '0;
            r_data    <= '0;
            r_last    <= 1'b0;
            r_out     <= '0;
            r_done    <= 1'b0;
            r_wrap    <= 1'b0;
            r_blk_cnt <= '0;
`ifdef GCTR_PARTIAL_EN
            r_bytes   <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (iICB_valid) begin
                        r_cb      <= iICB;
                        r_init    <= iICB[BLK_W-CNT_W:BLK_W-1];
                        r_blk_cnt <= '0;
                        r_wrap    <= 1'b0;
                    end
                end
                ST_WAIT_DATA: begin
                    if (iIn_valid) begin
                        r_data  <= iIn;
                        r_last  <= iIn_last;
`ifdef GCTR_PARTIAL_EN
                        r_bytes <= iIn_bytes;
`endif
                    end
                end
                ST_ENC: begin
                    if (iAES_done) begin
                        r_out     <= w_keyed;
                        r_cb      <= w_cb_next;
                        r_blk_cnt <= r_blk_cnt + 32'd1;
                        // sticky until the next ICB load
                        if (w_wrap) r_wrap <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (iOut_ready && r_last) r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign oOut      = r_out;
    assign oDone     = r_done;
    assign oWrap_err = r_wrap;
    assign oBlk_cnt  = r_blk_cnt;

endmodule

// File: tb/tb_gctr_ctrl.sv
// Testbench for gctr_ctrl: a default-width instance (CNT_W=32) and a narrow
// instance (CNT_W=8) run in lockstep from shared stimulus, each with an AES
// stub that echoes the counter block after 3 cycles.
module tb_gctr_ctrl;

    localparam int unsigned AES_L = 3;
`ifdef GCTR_PARTIAL_EN
    localparam bit PARTIAL = 1'b1;
`else
    localparam bit PARTIAL = 1'b0;
`endif

    logic         iClk = 1'b0;
    logic         iRst_n = 1'b0;
    logic         iClear = 1'b0;
    logic [0:127] iICB = '0;
    logic         iICB_valid = 1'b0;
    logic [0:127] iIn = '0;
    logic         iIn_last = 1'b0;
    logic         iIn_valid = 1'b0;
`ifdef GCTR_PARTIAL_EN
    logic [0:3]   iIn_bytes = '0;
`endif
    logic         iOut_ready = 1'b0;
    logic         iAES_done;
    logic [0:127] iAES_result, iAES_result8;

    logic         oICB_ready, oIn_ready, oAES_start, oOut_valid, oDone, oWrap_err;
    logic [0:127] oAES_block, oOut;
    logic [31:0]  oBlk_cnt;
    logic         oICB_ready8, oIn_ready8, oAES_start8, oOut_valid8, oDone8, oWrap_err8;
    logic [0:127] oAES_block8, oOut8;
    logic [31:0]  oBlk_cnt8;

    always #5 iClk = ~iClk;

    gctr_ctrl #(.CNT_W(32)) dut (
        .iClk(iClk), .iRst_n(iRst_n), .iClear(iClear),
        .iICB(iICB), .iICB_valid(iICB_valid), .oICB_ready(oICB_ready),
        .iIn(iIn), .iIn_last(iIn_last), .iIn_valid(iIn_valid),
`ifdef GCTR_PARTIAL_EN
        .iIn_bytes(iIn_bytes),
`endif
        .oIn_ready(oIn_ready), .oAES_block(oAES_block), .oAES_start(oAES_start),
        .iAES_done(iAES_done), .iAES_result(iAES_result),
        .oOut(oOut), .oOut_valid(oOut_valid), .iOut_ready(iOut_ready),
        .oDone(oDone), .oWrap_err(oWrap_err), .oBlk_cnt(oBlk_cnt)
    );

    gctr_ctrl #(.CNT_W(8)) dut8 (
        .iClk(iClk), .iRst_n(iRst_n), .iClear(iClear),
        .iICB(iICB), .iICB_valid(iICB_valid), .oICB_ready(oICB_ready8),
        .iIn(iIn), .iIn_last(iIn_last), .iIn_valid(iIn_valid),
`ifdef GCTR_PARTIAL_EN
        .iIn_bytes(iIn_bytes),
`endif
        .oIn_ready(oIn_ready8), .oAES_block(oAES_block8), .oAES_start(oAES_start8),
        .iAES_done(iAES_done), .iAES_result(iAES_result8),
        .oOut(oOut8), .oOut_valid(oOut_valid8), .iOut_ready(iOut_ready),
        .oDone(oDone8), .oWrap_err(oWrap_err8), .oBlk_cnt(oBlk_cnt8)
    );

    // AES stub: echo the block AES_L cycles after the start pulse
    int           s_cnt = 0;
    logic [0:127] s_blk = '0, s_blk8 = '0;
    always @(posedge iClk) begin
        if (oAES_start) begin
            s_blk  <= oAES_block;
            s_blk8 <= oAES_block8;
            s_cnt  <= AES_L;
        end else if (s_cnt != 0) begin
            s_cnt <= s_cnt - 1;
        end
    end
    assign iAES_done    = (s_cnt == 1);
    assign iAES_result  = iAES_done ? s_blk  : '0;
    assign iAES_result8 = iAES_done ? s_blk8 : '0;

    int              total = 0;
    int              bad = 0;
    logic [0:127]    m_icb = '0;
    longint unsigned m_k = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", name, got, exp);
        end
    endtask

    // Counter block for block index k: low w bits of the ICB advanced by k, mod 2^w
    function automatic logic [0:127] exp_cb(input logic [0:127] icb, input int unsigned w,
                                            input longint unsigned k);
        logic [127:0]    v, fm;
        longint unsigned m, f;
        v  = icb;
        m  = (64'd1 << w) - 64'd1;
        f  = (({32'd0, v[31:0]} & m) + k) & m;
        fm = {64'd0, m};
        v  = (v & ~fm) | {64'd0, f};
        return v;
    endfunction

    // Leading nb bytes kept (nb = 0 keeps all 16)
    function automatic logic [0:127] pmask(input logic [3:0] nb);
        logic [127:0] ones;
        ones = '1;
        if (nb == 4'd0) return ones;
        return ~(ones >> (8 * nb));
    endfunction

    task automatic load_icb(input logic [0:127] icb);
        int n = 0;
        while (!oICB_ready && n < 50) begin @(posedge iClk); #1; n++; end
        chk("icb_ready", oICB_ready, 1);
        iICB = icb;
        iICB_valid = 1'b1;
        @(posedge iClk); #1;
        iICB_valid = 1'b0;
        m_icb = icb;
        m_k = 0;
        chk("load_blk_cnt", oBlk_cnt, 0);
        chk("load_wrap", oWrap_err, 0);
        chk("load_wrap8", oWrap_err8, 0);
        chk("load_in_ready", oIn_ready, 1);
    endtask

    task automatic do_block(input logic [0:127] din, input logic last, input logic [3:0] nb,
                            input int stall, output logic [0:127] got);
        int           n = 0;
        logic [0:127] ea, ea8, eo, eo8, mk;
        ea  = exp_cb(m_icb, 32, m_k);
        ea8 = exp_cb(m_icb, 8, m_k);
        mk  = (last && PARTIAL) ? pmask(nb) : '1;
        eo  = (din ^ ea) & mk;
        eo8 = (din ^ ea8) & mk;
        while (!oIn_ready && n < 50) begin @(posedge iClk); #1; n++; end
        chk("in_ready", oIn_ready, 1);
        iIn = din;
        iIn_last = last;
`ifdef GCTR_PARTIAL_EN
        iIn_bytes = nb;
`endif
        iIn_valid = 1'b1;
        @(posedge iClk); #1;
        iIn_valid = 1'b0;
        iIn = {$urandom, $urandom, $urandom, $urandom};
        chk("aes_start", oAES_start, 1);
        chk("aes_block", oAES_block, ea);
        chk("aes_block8", oAES_block8, ea8);
        @(posedge iClk); #1;
        chk("start_one_cycle", oAES_start, 0);
        chk("enc_block_hold", oAES_block, ea);
        n = 1;
        while (!oOut_valid && n < 30) begin @(posedge iClk); #1; n++; end
        chk("out_latency", n, AES_L + 1);
        chk("out", oOut, eo);
        chk("out8", oOut8, eo8);
        chk("blk_cnt_inc", oBlk_cnt, m_k[31:0] + 32'd1);
        got = oOut;
        for (int s = 0; s < stall; s++) begin
            @(posedge iClk); #1;
            chk("stall_valid", oOut_valid, 1);
            chk("stall_out", oOut, eo);
            chk("stall_done", oDone, 0);
        end
        iOut_ready = 1'b1;
        @(posedge iClk); #1;
        iOut_ready = 1'b0;
        m_k++;
        chk("done", oDone, last);
        chk("done8", oDone8, last);
        chk("blk_cnt", oBlk_cnt, m_k[31:0]);
        chk("blk_cnt8", oBlk_cnt8, m_k[31:0]);
        chk("wrap", oWrap_err, m_k >= 64'h1_0000_0000);
        chk("wrap8", oWrap_err8, m_k >= 64'd256);
        chk("next_ready", last ? oICB_ready : oIn_ready, 1);
        if (last) begin
            @(posedge iClk); #1;
            chk("done_pulse", oDone, 0);
        end
    endtask

    typedef struct {
        logic [0:127] icb;
        logic [0:127] din;
        logic [0:127] exp_out;
    } vec_t;

    vec_t         vecs[4];
    logic [0:127] got, icb, din;

    initial begin
        vecs[0] = '{128'hCAFEBABE_FACEDBAD_DECAF888_00000001, 128'h0,
                    128'hCAFEBABE_FACEDBAD_DECAF888_00000001};
        vecs[1] = '{128'h0, {128{1'b1}}, {128{1'b1}}};
        vecs[2] = '{128'h00000000_00000000_00000000_12345678,
                    128'h00000000_00000000_00000000_FFFF0000,
                    128'h00000000_00000000_00000000_EDCB5678};
        vecs[3] = '{{16{8'hA5}}, {16{8'h5A}}, {128{1'b1}}};

        // 1. reset
        repeat (2) @(posedge iClk);
        #1 iRst_n = 1'b1;
        @(posedge iClk); #1;
        chk("rst_icb_ready", oICB_ready, 1);
        chk("rst_in_ready", oIn_ready, 0);
        chk("rst_start", oAES_start, 0);
        chk("rst_block", oAES_block, 0);
        chk("rst_out", oOut, 0);
        chk("rst_out_valid", oOut_valid, 0);
        chk("rst_done", oDone, 0);
        chk("rst_wrap", oWrap_err, 0);
        chk("rst_blk_cnt", oBlk_cnt, 0);

        // 2. single-block table
        for (int i = 0; i < 4; i++) begin
            load_icb(vecs[i].icb);
            do_block(vecs[i].din, 1'b1, 4'd0, 0, got);
            chk("vec_out", got, vecs[i].exp_out);
        end

        // 3. three blocks, block 2 stalled; stray ICB load in WAIT_DATA ignored
        load_icb(128'h01234567_89ABCDEF_02468ACE_00000001);
        iICB = '1;
        iICB_valid = 1'b1;
        @(posedge iClk); #1;
        iICB_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            din = {$urandom, $urandom, $urandom, $urandom};
            do_block(din, b == 2, 4'd0, (b == 1) ? 4 : 0, got);
        end
        chk("three_blk_cnt", oBlk_cnt, 3);

        // 4. counter wrap of the field
        load_icb(128'h11112222_33334444_55556666_FFFFFFFF);
        do_block(128'h0, 1'b0, 4'd0, 0, got);
        do_block(128'h0, 1'b1, 4'd0, 0, got);
        chk("wrap_low_word", got, 128'h11112222_33334444_55556666_00000000);
        chk("wrap_err_32", oWrap_err, 0);

        // 5. clear during ENC; the late AES done must be ignored
        load_icb(128'hDEADBEEF_00000000_00000000_00000010);
        iIn = '1;
        iIn_last = 1'b1;
        iIn_valid = 1'b1;
        @(posedge iClk); #1;
        iIn_valid = 1'b0;
        @(posedge iClk); #1;
        iClear = 1'b1;
        @(posedge iClk); #1;
        iClear = 1'b0;
        chk("clr_icb_ready", oICB_ready, 1);
        chk("clr_block", oAES_block, 0);
        chk("clr_out", oOut, 0);
        chk("clr_out_valid", oOut_valid, 0);
        chk("clr_blk_cnt", oBlk_cnt, 0);
        repeat (AES_L + 2) @(posedge iClk);
        #1;
        chk("clr_late_valid", oOut_valid, 0);
        chk("clr_late_blk_cnt", oBlk_cnt, 0);
        chk("clr_late_out", oOut, 0);
        chk("clr_late_in_ready", oIn_ready, 0);

`ifdef GCTR_PARTIAL_EN
        // 6. partial final block
        icb = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        din = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        load_icb(icb);
        do_block(din, 1'b1, 4'd5, 0, got);
        begin
            logic [127:0] g, x;
            g = got;
            x = din ^ icb;
            chk("partial_tail", g[87:0], 0);
            chk("partial_head", g[127:88], x[127:88]);
        end
`endif

        // random messages against the model
        for (int m = 0; m < 6; m++) begin
            int nblk;
            nblk = $urandom_range(1, 5);
            load_icb({$urandom, $urandom, $urandom, $urandom});
            for (int b = 0; b < nblk; b++) begin
                din = {$urandom, $urandom, $urandom, $urandom};
                do_block(din, b == nblk - 1, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), got);
            end
        end

        // long message: the CNT_W=8 instance wraps after block 256
        load_icb({$urandom, $urandom, $urandom, $urandom});
        for (int b = 0; b < 258; b++) begin
            din = {$urandom, $urandom, $urandom, $urandom};
            do_block(din, b == 257, 4'd0, 0, got);
        end
        chk("long_wrap8", oWrap_err8, 1);
        chk("long_wrap32", oWrap_err, 0);
        load_icb(128'h5);
        chk("reload_clears_wrap8", oWrap_err8, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/gctr_ctrl.md
Name: gctr_ctrl

Overview:
Consumes the 128-bit initial counter block produced by the ICB generator and runs the GCM GCTR data path. For each 128-bit data block it sends the current counter block to the AES core, XORs the returned keystream with the data, and increments the low counter field (inc32). It sits between the ICB generator, the AES core and the host data stream, and serves both encryption and decryption.

Parameters:
CNT_W, 32, width of the incremented counter field (bits [128-CNT_W:127]); legal range 8..32.

Ports:
iClk  in  1  clock
iRst_n  in  1  synchronous active-low reset
iClear  in  1  synchronous abort; returns the block to IDLE
iICB  in  [0:127]  initial counter block (CB1); bit 0 = MSB
iICB_valid  in  1  ICB valid
oICB_ready  out  1  high in IDLE only
iIn  in  [0:127]  plaintext or ciphertext block
iIn_last  in  1  marks the final block of the message
iIn_valid  in  1  input valid
oIn_ready  out  1  high in WAIT_DATA only
oAES_block  out  [0:127]  counter block to encrypt
oAES_start  out  1  one-cycle start pulse
iAES_done  in  1  one-cycle pulse; iAES_result is valid in the same cycle
iAES_result  in  [0:127]  keystream block
oOut  out  [0:127]  XOR result
oOut_valid  out  1  output valid
iOut_ready  in  1  downstream ready
oDone  out  1  one-cycle pulse after the last block is accepted downstream
oWrap_err  out  1  sticky counter-wrap error
oBlk_cnt  out  32  blocks completed since the ICB load

Behaviour:
- All state is synchronous. Priority: reset (iRst_n=0), then iClear, then normal operation.
- Reset and iClear drive state to IDLE and clear every output, internal register and flag to 0.
- FSM states: IDLE, WAIT_DATA, START, ENC, OUT.
- IDLE:
  - oICB_ready=1.
  - On iICB_valid: capture rCB<=iICB and rInit<=iICB[128-CNT_W:127]; clear oBlk_cnt and oWrap_err; go to WAIT_DATA.
- WAIT_DATA:
  - oIn_ready=1.
  - On iIn_valid: capture rData and rLast; go to START.
- START:
  - oAES_start=1 for exactly one cycle; oAES_block=rCB.
  - Go to ENC.
- ENC:
  - oAES_block holds rCB.
  - On iAES_done: rOut<=rData^iAES_result (masked per Optional Feature); increment the counter field; oBlk_cnt+1; go to OUT.
- OUT:
  - oOut_valid=1; oOut stays stable until iOut_ready.
  - On handshake: if rLast, go to IDLE and pulse oDone the next cycle; otherwise go to WAIT_DATA.
- Latency: input accepted at cycle t gives start at t+1, done at t+1+L (L≥1 AES cycles), and oOut_valid at t+2+L.
- Counter arithmetic:
  - Only bits [128-CNT_W:127] increment, modulo 2^CNT_W.
  - Bits [0:127-CNT_W] never change.
  - An all-ones field wraps to 0.
- Wrap error: set oWrap_err when the post-increment field equals rInit (2^CNT_W blocks processed). The flag stays set until the next ICB load or reset; processing continues.
- oBlk_cnt wraps modulo 2^32.
- Ignored inputs:
  - iAES_done outside ENC.
  - iICB_valid outside IDLE.
  - iIn_valid while oIn_ready=0.
- iOut_ready low: OUT holds indefinitely with no change to any output.

Optional Feature:
GCTR_PARTIAL_EN.
- Defined:
  - Adds input port iIn_bytes [0:3], captured with iIn.
  - When rLast=1, output bytes at index ≥ iIn_bytes are forced to 0. Byte 0 = bits [0:7]; iIn_bytes=0 means 16 valid bytes.
  - For non-last blocks, iIn_bytes is ignored.
- Undefined: the port is absent and every block is a full 128-bit XOR.

Decomposition:
- Shared package gcm_pkg holds:
  - state encoding constants;
  - BLK_W=128;
  - default CNT_W=32;
  - byte-mask helper function.
- One sub-module, gctr_inc: combinational inc32-style incrementer plus wrap compare against rInit. It is reusable by the GHASH/tag path.

Test Plan:
Common setup: the AES stub returns oAES_block unchanged after L=3 cycles.
1. Reset/idle: hold iRst_n=0 for 2 cycles, then release -> all outputs 0, oICB_ready=1 on the first cycle after release.
2. Single last block:
   - ICB=0xCAFEBABEFACEDBADDECAF888_00000001, iIn=0, iIn_last=1.
   - oAES_start pulses 1 cycle after accept.
   - oOut=0xCAFEBABEFACEDBADDECAF888_00000001 at t+5.
   - oDone pulses after the handshake; oBlk_cnt=1.
3. Three blocks, iOut_ready held low 4 cycles on block 2:
   - oAES_block low words 00000001, 00000002, 00000003.
   - Block-2 output stable across the stall; oBlk_cnt=3.
4. Wrap:
   - ICB low word=0xFFFFFFFF, 2 blocks.
   - Second oAES_block low word=0x00000000; upper 96 bits unchanged; oWrap_err=0.
   - With CNT_W=8 and 256 blocks: oWrap_err=1 after block 256.
5. iClear asserted in ENC -> IDLE next cycle, all outputs 0; a later iAES_done is ignored.
6. GCTR_PARTIAL_EN: last block with iIn_bytes=5 -> oOut bytes 5..15 equal 0x00, bytes 0..4 equal iIn^keystream.
